pci_initiator_32: RTL and testbench
===================================

// Module: pci_initiator_32
// PURPOSE
//  Bus-master (initiator) side of the team's 32-bit PCI-style target interface.
//  Accepts one burst command from local logic and drives word address, write data, byte enables and we.
//  Samples the target's devsel_32, last_add and read data, then reports completion or master abort.
//  Sits between the DMA/control logic and the sram_32-class targets. Every bus output is registered.
// PARAMETERS
//  LEN_W      8             width of burst_len and beats_done
//  IDLE_ADDR  32'h0000_0000 add_out value driven while idle
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous active-high reset
//  start        in   1      one-cycle command strobe; sampled only in IDLE
//  cmd_we       in   1      1 = write burst, 0 = read burst
//  start_addr   in   30     first word address (byte address [31:2])
//  burst_len    in   LEN_W  number of beats requested
//  wr_data      in   32     write data for the current beat
//  wr_be        in   4      byte enables for the current beat (1 = byte enabled)
//  wr_pop       out  1      1-cycle pulse: wr_data/wr_be consumed; present the next beat's data next cycle
//  rd_data      out  32     read beat data
//  rd_valid     out  1      1-cycle pulse: rd_data valid
//  busy         out  1      1 from accept until done
//  done         out  1      1-cycle pulse at burst end
//  abort        out  1      valid with done: 1 = master abort (no devsel)
//  beats_done   out  LEN_W  successful beats; valid with done, held until next start
//  add_out      out  32     bus byte address {word_addr,2'b00}
//  data_out     out  32     bus write data
//  be_out       out  4      bus byte enables
//  we_out       out  1      bus write enable
//  req_64       out  1      64-bit request; tied 0
//  devsel_32    in   1      target select, active low; registered by the target
//  last_add     in   1      target is at its end address (disconnect)
//  data_in      in   32     target read data; Z when not selected
// BEHAVIOUR
//  Reset:
//   - rst=1 -> state IDLE; add_out=IDLE_ADDR; data_out, be_out, we_out, req_64 = 0.
//   - rd_data, rd_valid, wr_pop, busy, done, abort, beats_done = 0.
//   - Reset mid-burst drops the burst; no done pulse.
//  FSM states: IDLE, DRIVE, RESP, FIN. Each beat takes 2 cycles (DRIVE + RESP).
//  IDLE
//   - start=1 and burst_len!=0 -> DRIVE.
//   - Latch cmd_we and burst_len; word pointer = start_addr.
//   - Register add_out={start_addr,2'b00}; we_out=cmd_we.
//   - Write: data_out=wr_data, be_out=wr_be, wr_pop=1. Read: be_out=4'hF.
//   - beats_done cleared. start with burst_len==0 is ignored.
//  DRIVE -> RESP unconditionally; bus outputs held. The target registers its response on this edge.
//  RESP: on the edge leaving RESP, sample devsel_32, last_add and data_in.
//   - devsel_32=1: master abort -> FIN with abort=1. No rd_valid; beats_done unchanged.
//   - devsel_32=0: beat successful; beats_done+1. Read: rd_data=data_in, rd_valid=1.
//   - After a successful beat:
//     - If beats_done+1==burst_len or last_add=1 -> FIN with abort=0.
//     - Otherwise pointer+1 (mod 2^30, wraps 3FFFFFFF->0) -> DRIVE with new add_out.
//     - Write: the new beat's data_out/be_out load from wr_data/wr_be with wr_pop=1.
//  FIN
//   - done=1 for one cycle. busy stays 1 during FIN and falls to 0 on the next edge, together with done.
//   - we_out=0, add_out=IDLE_ADDR, be_out=0 -> IDLE.
//  Ordering and busy rules:
//   - last_add and count reached on the same beat -> normal completion, abort=0.
//   - start while busy is ignored. Write data/be are held through RESP, so a target re-write is idempotent.
//   - data_in is captured only when devsel_32=0, so Z never reaches rd_data.
//  Throughput: N-beat burst = 2N+1 cycles from start to done.
// TESTING
//  Bench target window word 0x10..0x13 throughout.
//  1 write, addr 0x10, len 4, data A0..A3, be F
//     -> 4 wr_pop pulses, done 9 cycles after start, beats_done=4, abort=0, mem[0x10..0x13]=A0..A3.
//  2 read, addr 0x12, len 8
//     -> last_add on 0x13 ends early: 2 rd_valid (mem[0x12], mem[0x13]), beats_done=2, abort=0.
//  3 read, addr 0x20, len 3
//     -> devsel_32 stays 1: done+abort 3 cycles after start, beats_done=0, no rd_valid.
//  4 write, len 4, rst asserted during beat 2
//     -> next cycle IDLE, we_out=0, busy=0, no done; a following 1-beat read works normally.
//  5 start pulsed while busy, and a separate start with burst_len=0 -> both ignored; the ongoing burst is unaffected.
//  6 read, addr 0x3FFFFFFF, len 2, window opened to include it
//     -> add_out 0xFFFFFFFC then 0x00000000, beats_done=2.

Source files
------------

// File: rtl/pci_initiator_32.sv
// Bus-master side of the 32-bit PCI-style target interface: runs one read or
// write burst per command, two cycles per beat, with fully registered bus outputs.
module pci_initiator_32 #(
   parameter int          LEN_W     = 8,
   parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cmd_we,
   input  logic [29:0]      start_addr,
   input  logic [LEN_W-1:0] burst_len,
   input  logic [31:0]      wr_data,
   input  logic [3:0]       wr_be,
   output logic             wr_pop,
   output logic [31:0]      rd_data,
   output logic             rd_valid,
   output logic             busy,
   output logic             done,
   output logic             abort,
   output logic [LEN_W-1:0] beats_done,
   output logic [31:0]      add_out,
   output logic [31:0]      data_out,
   output logic [3:0]       be_out,
   output logic             we_out,
   output logic             req_64,
   input  logic             devsel_32,
   input  logic             last_add,
   input  logic [31:0]      data_in
);

   typedef enum logic [1:0] {IDLE, DRIVE, RESP, FIN} state_t;

   localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

   state_t           state_reg, state_next;
   logic [29:0]      ptr_reg, ptr_next;
   logic [LEN_W-1:0] len_reg, len_next;
   logic             we_reg, we_next;
   logic [LEN_W-1:0] beats_reg, beats_next;
   logic [31:0]      add_out_reg, add_out_next;
   logic [31:0]      data_out_reg, data_out_next;
   logic [3:0]       be_out_reg, be_out_next;
   logic             we_out_reg, we_out_next;
   logic             wr_pop_reg, wr_pop_next;
   logic [31:0]      rd_data_reg, rd_data_next;
   logic             rd_valid_reg, rd_valid_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;
   logic             abort_reg, abort_next;
   logic [LEN_W-1:0] beats_inc;
   logic [29:0]      ptr_inc;

   assign beats_inc = beats_reg + ONE;
   assign ptr_inc   = ptr_reg + 30'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         ptr_reg      <= '0;
         len_reg      <= '0;
         we_reg       <= 1'b0;
         beats_reg    <= '0;
         add_out_reg  <= IDLE_ADDR;
         data_out_reg <= '0;
         be_out_reg   <= '0;
         we_out_reg   <= 1'b0;
         wr_pop_reg   <= 1'b0;
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         abort_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         ptr_reg      <= ptr_next;
         len_reg      <= len_next;
         we_reg       <= we_next;
         beats_reg    <= beats_next;
         add_out_reg  <= add_out_next;
         data_out_reg <= data_out_next;
         be_out_reg   <= be_out_next;
         we_out_reg   <= we_out_next;
         wr_pop_reg   <= wr_pop_next;
         rd_data_reg  <= rd_data_next;
         rd_valid_reg <= rd_valid_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         abort_reg    <= abort_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      ptr_next      = ptr_reg;
      len_next      = len_reg;
      we_next       = we_reg;
      beats_next    = beats_reg;
      add_out_next  = add_out_reg;
      data_out_next = data_out_reg;
      be_out_next   = be_out_reg;
      we_out_next   = we_out_reg;
      wr_pop_next   = 1'b0;
      rd_data_next  = rd_data_reg;
      rd_valid_next = 1'b0;
      busy_next     = busy_reg;
      done_next     = 1'b0;
      abort_next    = abort_reg;

      case (state_reg)
         IDLE: begin
            if (start && burst_len != '0) begin
               state_next   = DRIVE;
               we_next      = cmd_we;
               len_next     = burst_len;
               ptr_next     = start_addr;
               beats_next   = '0;
               abort_next   = 1'b0;
               busy_next    = 1'b1;
               add_out_next = {start_addr, 2'b00};
               we_out_next  = cmd_we;
               if (cmd_we) begin
                  data_out_next = wr_data;
                  be_out_next   = wr_be;
                  wr_pop_next   = 1'b1;
               end else begin
                  data_out_next = '0;
                  be_out_next   = 4'hF;
               end
            end
         end
         DRIVE: state_next = RESP;
         RESP: begin
            // Bus returns to idle as soon as the burst ends so FIN never drives a beat.
            if (devsel_32) begin
               state_next    = FIN;
               abort_next    = 1'b1;
               done_next     = 1'b1;
               add_out_next  = IDLE_ADDR;
               data_out_next = '0;
               be_out_next   = '0;
               we_out_next   = 1'b0;
            end else begin
               beats_next = beats_inc;
               if (!we_reg) begin
                  rd_data_next  = data_in;
                  rd_valid_next = 1'b1;
               end
               if (beats_inc == len_reg || last_add) begin
                  state_next    = FIN;
                  abort_next    = 1'b0;
                  done_next     = 1'b1;
                  add_out_next  = IDLE_ADDR;
                  data_out_next = '0;
                  be_out_next   = '0;
                  we_out_next   = 1'b0;
               end else begin
                  state_next   = DRIVE;
                  ptr_next     = ptr_inc;
                  add_out_next = {ptr_inc, 2'b00};
                  if (we_reg) begin
                     data_out_next = wr_data;
                     be_out_next   = wr_be;
                     wr_pop_next   = 1'b1;
                  end
               end
            end
         end
         FIN: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
         default: state_next = IDLE;
      endcase
   end

   assign wr_pop     = wr_pop_reg;
   assign rd_data    = rd_data_reg;
   assign rd_valid   = rd_valid_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign abort      = abort_reg;
   assign beats_done = beats_reg;
   assign add_out    = add_out_reg;
   assign data_out   = data_out_reg;
   assign be_out     = be_out_reg;
   assign we_out     = we_out_reg;
   assign req_64     = 1'b0;

endmodule

// File: tb/tb_pci_initiator_32.sv
// Bench for pci_initiator_32: a small registered target model on words 0x10..0x13,
// a table of bursts, plus reset-mid-burst and zero-length command sequences.
module tb_pci_initiator_32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        cmd_we = 1'b0;
   logic [29:0] start_addr = '0;
   logic [7:0]  burst_len = '0;
   logic [31:0] wr_data;
   logic [3:0]  wr_be = 4'hF;
   logic        wr_pop;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        busy;
   logic        done;
   logic        abort;
   logic [7:0]  beats_done;
   logic [31:0] add_out;
   logic [31:0] data_out;
   logic [3:0]  be_out;
   logic        we_out;
   logic        req_64;
   logic        devsel_32 = 1'b1;
   logic        last_add = 1'b0;
   logic [31:0] data_in = '0;

   always #5 clk = ~clk;

   pci_initiator_32 #(.LEN_W(8), .IDLE_ADDR(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .start(start), .cmd_we(cmd_we), .start_addr(start_addr),
      .burst_len(burst_len), .wr_data(wr_data), .wr_be(wr_be), .wr_pop(wr_pop),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .abort(abort),
      .beats_done(beats_done), .add_out(add_out), .data_out(data_out), .be_out(be_out),
      .we_out(we_out), .req_64(req_64), .devsel_32(devsel_32), .last_add(last_add),
      .data_in(data_in)
   );

   // Target model: registers select/last/data on every edge, writes while selected.
   logic [31:0] mem [0:31];
   logic        wrap_en = 1'b0;

   always @(posedge clk) begin
      logic [29:0] a;
      logic        sel;
      a   = add_out[31:2];
      sel = (a >= 30'h10 && a <= 30'h13) || (wrap_en && (a == 30'h3FFF_FFFF || a == 30'h0));
      devsel_32 <= !sel;
      last_add  <= sel && (a == 30'h13);
      data_in   <= sel ? mem[a[4:0]] : 32'h0BAD_F00D;
      if (sel && we_out) begin
         for (int b = 0; b < 4; b++)
            if (be_out[b]) mem[a[4:0]][b*8 +: 8] <= data_out[b*8 +: 8];
      end
   end

   // Local write-data source: advances one word per wr_pop.
   logic [31:0] cur_wbase = '0;
   int          widx = 0;
   always @(posedge clk) if (wr_pop) widx <= widx + 1;
   assign wr_data = cur_wbase + 32'(widx);

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [29:0] addr;
      logic [7:0]  len;
      logic [31:0] wbase;
      logic        wrap;
      logic        inject;
      int          exp_cyc;
      logic [7:0]  exp_beats;
      logic        exp_abort;
      int          exp_pops;
      int          exp_rdv;
      logic [31:0] exp_rd_first;
      logic [31:0] exp_rd_last;
      logic        chk_a3;
      logic [31:0] exp_a3;
   } vec_t;

   task automatic run_vec(input int id, input vec_t v);
      int          cyc, pops, rdv;
      logic [31:0] rd_first, rd_last, a1, a3;
      logic        busy_ok, got_done;
      logic [7:0]  bd;
      logic        ab;
      @(negedge clk);
      wrap_en    = v.wrap;
      cur_wbase  = v.wbase;
      widx       = 0;
      cmd_we     = v.we;
      start_addr = v.addr;
      burst_len  = v.len;
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 1; pops = 0; rdv = 0; rd_first = '0; rd_last = '0; a1 = add_out; a3 = '0;
      busy_ok = 1'b1; got_done = 1'b0; bd = '0; ab = 1'b0;
      forever begin
         if (wr_pop) pops++;
         if (rd_valid) begin
            if (rdv == 0) rd_first = rd_data;
            rd_last = rd_data;
            rdv++;
         end
         if (cyc == 3) a3 = add_out;
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            got_done = 1'b1; bd = beats_done; ab = abort;
            break;
         end
         if (cyc > 60) break;
         if (v.inject && cyc == 2) begin
            start = 1'b1; cmd_we = 1'b1; start_addr = 30'h20; burst_len = 8'd5;
         end
         @(posedge clk);
         #1 start = 1'b0;
         cyc++;
      end
      $display("vec %0d: we=%0d addr=%h len=%0d -> cycles=%0d beats=%0d abort=%0d pops=%0d rdv=%0d",
               id, v.we, v.addr, v.len, cyc, bd, ab, pops, rdv);
      chk($sformatf("v%0d done_seen", id), 32'(got_done), 32'd1);
      chk($sformatf("v%0d cycles", id), 32'(cyc), 32'(v.exp_cyc));
      chk($sformatf("v%0d beats_done", id), 32'(bd), 32'(v.exp_beats));
      chk($sformatf("v%0d abort", id), 32'(ab), 32'(v.exp_abort));
      chk($sformatf("v%0d wr_pops", id), 32'(pops), 32'(v.exp_pops));
      chk($sformatf("v%0d rd_valids", id), 32'(rdv), 32'(v.exp_rdv));
      chk($sformatf("v%0d busy_held", id), 32'(busy_ok), 32'd1);
      chk($sformatf("v%0d first_add", id), a1, {v.addr, 2'b00});
      if (v.exp_rdv > 0) begin
         chk($sformatf("v%0d rd_first", id), rd_first, v.exp_rd_first);
         chk($sformatf("v%0d rd_last", id), rd_last, v.exp_rd_last);
      end
      if (v.chk_a3) chk($sformatf("v%0d third_add", id), a3, v.exp_a3);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d done_cleared", id), 32'(done), 32'd0);
      chk($sformatf("v%0d busy_cleared", id), 32'(busy), 32'd0);
      chk($sformatf("v%0d beats_held", id), 32'(beats_done), 32'(v.exp_beats));
      wrap_en = 1'b0;
   endtask

   vec_t vecs [0:6];
   vec_t tail;

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      mem[31] = 32'h0000_0031;
      mem[0]  = 32'h0000_0030;

      vecs[0] = '{we:1'b1, addr:30'h10, len:8'd4, wbase:32'hA0, wrap:1'b0, inject:1'b0,
                  exp_cyc:9, exp_beats:8'd4, exp_abort:1'b0, exp_pops:4, exp_rdv:0,
                  exp_rd_first:32'h0, exp_rd_last:32'h0, chk_a3:1'b1, exp_a3:32'h44};
      vecs[1] = '{we:1'b0, addr:30'h12, len:8'd8, wbase:32'h0, wrap:1'b0, inject:1'b0,
                  exp_cyc:5, exp_beats:8'd2, exp_abort:1'b0, exp_pops:0, exp_rdv:2,
                  exp_rd_first:32'hA2, exp_rd_last:32'hA3, chk_a3:1'b1, exp_a3:32'h4C};
      vecs[2] = '{we:1'b0, addr:30'h20, len:8'd3, wbase:32'h0, wrap:1'b0, inject:1'b0,
                  exp_cyc:3, exp_beats:8'd0, exp_abort:1'b1, exp_pops:0, exp_rdv:0,
                  exp_rd_first:32'h0, exp_rd_last:32'h0, chk_a3:1'b0, exp_a3:32'h0};
      vecs[3] = '{we:1'b0, addr:30'h10, len:8'd4, wbase:32'h0, wrap:1'b0, inject:1'b1,
                  exp_cyc:9, exp_beats:8'd4, exp_abort:1'b0, exp_pops:0, exp_rdv:4,
                  exp_rd_first:32'hA0, exp_rd_last:32'hA3, chk_a3:1'b1, exp_a3:32'h44};
      vecs[4] = '{we:1'b1, addr:30'h13, len:8'd3, wbase:32'hB0, wrap:1'b0, inject:1'b0,
                  exp_cyc:3, exp_beats:8'd1, exp_abort:1'b0, exp_pops:1, exp_rdv:0,
                  exp_rd_first:32'h0, exp_rd_last:32'h0, chk_a3:1'b0, exp_a3:32'h0};
      vecs[5] = '{we:1'b0, addr:30'h13, len:8'd1, wbase:32'h0, wrap:1'b0, inject:1'b0,
                  exp_cyc:3, exp_beats:8'd1, exp_abort:1'b0, exp_pops:0, exp_rdv:1,
                  exp_rd_first:32'hB0, exp_rd_last:32'hB0, chk_a3:1'b0, exp_a3:32'h0};
      vecs[6] = '{we:1'b0, addr:30'h3FFF_FFFF, len:8'd2, wbase:32'h0, wrap:1'b1, inject:1'b0,
                  exp_cyc:5, exp_beats:8'd2, exp_abort:1'b0, exp_pops:0, exp_rdv:2,
                  exp_rd_first:32'h31, exp_rd_last:32'h30, chk_a3:1'b1, exp_a3:32'h0};
      tail    = '{we:1'b0, addr:30'h10, len:8'd1, wbase:32'h0, wrap:1'b0, inject:1'b0,
                  exp_cyc:3, exp_beats:8'd1, exp_abort:1'b0, exp_pops:0, exp_rdv:1,
                  exp_rd_first:32'hC0, exp_rd_last:32'hC0, chk_a3:1'b0, exp_a3:32'h0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst add_out", add_out, 32'h0);
      chk("rst data_out", data_out, 32'h0);
      chk("rst be_out", 32'(be_out), 32'h0);
      chk("rst we_out", 32'(we_out), 32'h0);
      chk("rst req_64", 32'(req_64), 32'h0);
      chk("rst busy", 32'(busy), 32'h0);
      chk("rst done", 32'(done), 32'h0);
      chk("rst abort", 32'(abort), 32'h0);
      chk("rst beats_done", 32'(beats_done), 32'h0);
      chk("rst rd_valid", 32'(rd_valid), 32'h0);
      chk("rst wr_pop", 32'(wr_pop), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run_vec(i, vecs[i]);
         if (i == 0)
            for (int k = 0; k < 4; k++)
               chk($sformatf("mem[%0h]", 16 + k), mem[16 + k], 32'hA0 + 32'(k));
      end

      // Zero-length command is ignored
      @(negedge clk);
      cmd_we = 1'b1; start_addr = 30'h10; burst_len = 8'd0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("len0 busy", 32'(busy), 32'd0);
      chk("len0 wr_pop", 32'(wr_pop), 32'd0);
      chk("len0 we_out", 32'(we_out), 32'd0);
      $display("len0 start: busy=%0d wr_pop=%0d", busy, wr_pop);

      // Reset during beat 2 of a 4-beat write
      @(negedge clk);
      cur_wbase = 32'hC0; widx = 0;
      cmd_we = 1'b1; start_addr = 30'h10; burst_len = 8'd4; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst we_out", 32'(we_out), 32'd0);
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst add_out", add_out, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      begin
         logic seen;
         seen = 1'b0;
         repeat (4) begin
            @(posedge clk);
            #1 if (done || busy) seen = 1'b1;
         end
         chk("midrst quiet", 32'(seen), 32'd0);
         $display("reset mid-burst: quiet=%0d", !seen);
      end
      run_vec(7, tail);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
